brent_kung_adder_pipe: RTL and testbench



---
 rtl/brent_kung_pkg.sv | 29 ++
 rtl/bk_prefix_cell.sv | 18 +
 rtl/brent_kung_adder_pipe.sv | 195 +++++++++++++++++++
 tb/tb_brent_kung_adder_pipe.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brent_kung_pkg.sv
// ----------------------------------------------------------------------------
// brent_kung_pkg
// Shared types and helpers for the pipelined Brent-Kung adder/subtractor.
//   gp_t        : one prefix-tree node, {generate, propagate}
//   bk_combine  : the black-cell operator, (hi o lo)
//   bk_levels   : number of tree levels for a given operand width
// ----------------------------------------------------------------------------
package brent_kung_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    localparam int BK_DEFAULT_WIDTH = 16;

    // Associative prefix operator: hi covers the more significant span.
    function automatic gp_t bk_combine(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

    function automatic int bk_levels(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/bk_prefix_cell.sv
// ----------------------------------------------------------------------------
// bk_prefix_cell
// Combinational black cell of the Brent-Kung tree.
//   hi_i : group {G,P} of the more significant span
//   lo_i : group {G,P} of the adjacent less significant span
//   gp_o : merged group {G,P} covering both spans
// ----------------------------------------------------------------------------
module bk_prefix_cell
    import brent_kung_pkg::*;
(
    input  gp_t hi_i,
    input  gp_t lo_i,
    output gp_t gp_o
);

    assign gp_o = bk_combine(hi_i, lo_i);

endmodule

// File: rtl/brent_kung_adder_pipe.sv
// ----------------------------------------------------------------------------
// brent_kung_adder_pipe
// Three-stage elastic Brent-Kung adder/subtractor with valid/ready streams.
//   Stage 1 registers bitwise g/p, stage 2 the up-sweep, stage 3 the
//   down-sweep, sum and flags.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid / in_ready : input handshake for A, B, Cin, sub
//   A, B                : WIDTH-bit operands
//   Cin                 : carry-in (add) or borrow-in (sub)
//   sub                 : 0 = A+B+Cin, 1 = A-B-Cin
//   out_valid/out_ready : output handshake for Sum, Cout, Ovf, Zero
//   Sum                 : WIDTH-bit result
//   Cout                : raw carry out of the MSB (1 = no borrow in sub)
//   Ovf                 : two's-complement overflow
//   Zero                : Sum == 0
// ----------------------------------------------------------------------------
module brent_kung_adder_pipe
    import brent_kung_pkg::*;
#(
    parameter int WIDTH = BK_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int LVL = bk_levels(WIDTH);

    // ---------------- stage control ----------------
    logic vld_p1_q, vld_p2_q, vld_p3_q;
    logic vld_p1_d, vld_p2_d, vld_p3_d;
    logic en_p1, en_p2, en_p3;
    logic ld_p1, ld_p2, ld_p3;

    // A stage may load when empty or when its occupant leaves this cycle.
    assign en_p3    = !vld_p3_q || out_ready;
    assign en_p2    = !vld_p2_q || en_p3;
    assign en_p1    = !vld_p1_q || en_p2;
    assign in_ready = rst_n && en_p1;

    assign ld_p1 = in_valid && in_ready;
    assign ld_p2 = en_p2 && vld_p1_q;
    assign ld_p3 = en_p3 && vld_p2_q;

    assign vld_p1_d = en_p1 ? ld_p1    : vld_p1_q;
    assign vld_p2_d = en_p2 ? vld_p1_q : vld_p2_q;
    assign vld_p3_d = en_p3 ? vld_p2_q : vld_p3_q;

    // ---------------- stage 0 -> 1: bitwise generate/propagate ----------------
    logic [WIDTH-1:0] bx_p0;
    logic             c0_p0;
    logic [WIDTH-1:0] g_p0, p_p0;

    assign bx_p0 = sub ? ~B : B;
    assign c0_p0 = sub ? ~Cin : Cin;
    assign p_p0  = A ^ bx_p0;
    // Carry-in is absorbed into bit 0 so the tree needs no separate c0 input.
    assign g_p0  = (A & bx_p0) | {{(WIDTH-1){1'b0}}, p_p0[0] & c0_p0};

    logic [WIDTH-1:0] g_p1_q, p_p1_q;
    logic             a_msb_p1_q, bx_msb_p1_q, c0_p1_q;

    always_ff @(posedge clk) begin
        if (ld_p1) begin
            g_p1_q      <= g_p0;
            p_p1_q      <= p_p0;
            a_msb_p1_q  <= A[WIDTH-1];
            bx_msb_p1_q <= bx_p0[WIDTH-1];
            c0_p1_q     <= c0_p0;
        end
    end

    // ---------------- stage 1 -> 2: up-sweep ----------------
    gp_t up_w [LVL+1][WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_up_in
        assign up_w[0][i] = '{g: g_p1_q[i], p: p_p1_q[i]};
    end

    for (genvar l = 0; l < LVL; l++) begin : g_up_lvl
        for (genvar i = 0; i < WIDTH; i++) begin : g_node
            if (((i + 1) % (2 ** (l + 1))) == 0) begin : g_cell
                bk_prefix_cell u_cell (
                    .hi_i (up_w[l][i]),
                    .lo_i (up_w[l][i - (2 ** l)]),
                    .gp_o (up_w[l+1][i])
                );
            end else begin : g_pass
                assign up_w[l+1][i] = up_w[l][i];
            end
        end
    end

    gp_t [WIDTH-1:0]  gp_p2_q;
    logic [WIDTH-1:0] p_p2_q;
    logic             a_msb_p2_q, bx_msb_p2_q, c0_p2_q;

    always_ff @(posedge clk) begin
        if (ld_p2) begin
            for (int i = 0; i < WIDTH; i++) begin
                gp_p2_q[i] <= up_w[LVL][i];
            end
            p_p2_q      <= p_p1_q;
            a_msb_p2_q  <= a_msb_p1_q;
            bx_msb_p2_q <= bx_msb_p1_q;
            c0_p2_q     <= c0_p1_q;
        end
    end

    // ---------------- stage 2 -> 3: down-sweep, sum, flags ----------------
    gp_t dn_w [LVL][WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_dn_in
        assign dn_w[0][i] = gp_p2_q[i];
    end

    // Fill in the prefixes the up-sweep left partial, widest span first.
    for (genvar k = 0; k < LVL - 1; k++) begin : g_dn_lvl
        localparam int STEP = 1 << (LVL - 2 - k);
        for (genvar i = 0; i < WIDTH; i++) begin : g_node
            if ((((i + 1) % (2 * STEP)) == STEP) && ((i + 1) >= 3 * STEP)) begin : g_cell
                bk_prefix_cell u_cell (
                    .hi_i (dn_w[k][i]),
                    .lo_i (dn_w[k][i - STEP]),
                    .gp_o (dn_w[k+1][i])
                );
            end else begin : g_pass
                assign dn_w[k+1][i] = dn_w[k][i];
            end
        end
    end

    // carry_w[i] is the carry out of bit i (prefix G[i:0], c0 included).
    logic [WIDTH-1:0] carry_w;
    logic [WIDTH-1:0] unused_dn_p;

    for (genvar i = 0; i < WIDTH; i++) begin : g_carry
        assign carry_w[i]     = dn_w[LVL-1][i].g;
        assign unused_dn_p[i] = dn_w[LVL-1][i].p;
    end

    logic [WIDTH-1:0] sum_d;
    logic             cout_d, ovf_d, zero_d;

    always_comb begin
        sum_d  = p_p2_q ^ {carry_w[WIDTH-2:0], c0_p2_q};
        cout_d = carry_w[WIDTH-1];
        ovf_d  = (a_msb_p2_q == bx_msb_p2_q) && (sum_d[WIDTH-1] != a_msb_p2_q);
        zero_d = (sum_d == '0);
    end

    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q, zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            vld_p3_q <= vld_p3_d;
            if (ld_p3) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign out_valid = vld_p3_q;
    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_brent_kung_adder_pipe.sv
// ----------------------------------------------------------------------------
// tb_brent_kung_adder_pipe
// Bench for brent_kung_adder_pipe at WIDTH = 8, 16 and 32 (index 0, 1, 2).
// Expected results are queued when an operand is accepted and compared in
// order when the matching DUT hands a result downstream.
// ----------------------------------------------------------------------------
module tb_brent_kung_adder_pipe;

    localparam int NW = 3;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid  [NW];
    logic        in_ready  [NW];
    logic        out_valid [NW];
    logic        out_ready [NW];
    logic [63:0] a_s       [NW];
    logic [63:0] b_s       [NW];
    logic [63:0] sum_s     [NW];
    logic        cin_s     [NW];
    logic        sub_s     [NW];
    logic        cout_s    [NW];
    logic        ovf_s     [NW];
    logic        zero_s    [NW];

    logic [7:0]  sum8;
    logic [15:0] sum16;
    logic [31:0] sum32;

    assign sum_s[0] = {56'd0, sum8};
    assign sum_s[1] = {48'd0, sum16};
    assign sum_s[2] = {32'd0, sum32};

    brent_kung_adder_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .A(a_s[0][7:0]), .B(b_s[0][7:0]), .Cin(cin_s[0]), .sub(sub_s[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .Sum(sum8),
        .Cout(cout_s[0]), .Ovf(ovf_s[0]), .Zero(zero_s[0])
    );

    brent_kung_adder_pipe #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .A(a_s[1][15:0]), .B(b_s[1][15:0]), .Cin(cin_s[1]), .sub(sub_s[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .Sum(sum16),
        .Cout(cout_s[1]), .Ovf(ovf_s[1]), .Zero(zero_s[1])
    );

    brent_kung_adder_pipe #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .A(a_s[2][31:0]), .B(b_s[2][31:0]), .Cin(cin_s[2]), .sub(sub_s[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .Sum(sum32),
        .Cout(cout_s[2]), .Ovf(ovf_s[2]), .Zero(zero_s[2])
    );

    int   checks = 0;
    int   errors = 0;
    int   sent_cnt [NW];
    int   nout     [NW];
    exp_t q        [NW][$];
    exp_t mon_e;
    bit   rand_done;

    // Reference: plain wide addition of the effective operands.
    function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sb);
        logic [63:0] mask, am, bx, s;
        logic [64:0] full;
        exp_t        e;
        mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        am     = a & mask;
        bx     = (sb ? ~b : b) & mask;
        full   = {1'b0, am} + {1'b0, bx} + {64'd0, (sb ? ~cin : cin)};
        s      = full[63:0] & mask;
        e.sum  = s;
        e.cout = full[w];
        e.ovf  = (am[w-1] == bx[w-1]) && (s[w-1] != am[w-1]);
        e.zero = (s == 64'd0);
        return e;
    endfunction

    function automatic exp_t mk(input logic [63:0] s, input logic c, input logic o, input logic z);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.ovf  = o;
        e.zero = z;
        return e;
    endfunction

    // Output scoreboard: a result transfers at the next rising edge.
    always @(negedge clk) begin
        for (int k = 0; k < NW; k++) begin
            if (rst_n && out_valid[k] && out_ready[k]) begin
                checks++;
                nout[k]++;
                if (q[k].size() == 0) begin
                    errors++;
                    $display("FAIL out_extra dut%0d: got sum=%h with nothing outstanding", k, sum_s[k]);
                end else begin
                    mon_e = q[k].pop_front();
                    if ({sum_s[k], cout_s[k], ovf_s[k], zero_s[k]} !== mon_e) begin
                        errors++;
                        $display("FAIL out_data dut%0d: got sum=%h c=%b o=%b z=%b, expected sum=%h c=%b o=%b z=%b",
                                 k, sum_s[k], cout_s[k], ovf_s[k], zero_s[k],
                                 mon_e.sum, mon_e.cout, mon_e.ovf, mon_e.zero);
                    end
                end
            end
        end
    end

    task automatic send(input int k, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic sb, input exp_t e);
        bit done;
        done      = 1'b0;
        a_s[k]    = a;
        b_s[k]    = b;
        cin_s[k]  = cin;
        sub_s[k]  = sb;
        in_valid[k] = 1'b1;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            if (in_ready[k]) begin
                q[k].push_back(e);
                sent_cnt[k]++;
                done = 1'b1;
            end
            @(posedge clk);
        end
        #1;
        in_valid[k] = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout dut%0d: in_ready stayed 0, required 1", k);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        for (int k = 0; k < NW; k++) begin
            in_valid[k] = 1'b0; out_ready[k] = 1'b1;
            a_s[k] = '0; b_s[k] = '0; cin_s[k] = 1'b0; sub_s[k] = 1'b0;
            sent_cnt[k] = 0; nout[k] = 0;
        end
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NW; k++) begin
            checks++;
            if (out_valid[k] !== 1'b0) begin
                errors++; $display("FAIL rst_out_valid dut%0d: got %b, expected 0", k, out_valid[k]);
            end
            checks++;
            if ({sum_s[k], cout_s[k], ovf_s[k], zero_s[k]} !== 67'd0) begin
                errors++; $display("FAIL rst_outputs dut%0d: got sum=%h c=%b o=%b z=%b, expected all 0",
                                   k, sum_s[k], cout_s[k], ovf_s[k], zero_s[k]);
            end
            checks++;
            if (in_ready[k] !== 1'b0) begin
                errors++; $display("FAIL rst_in_ready dut%0d: got %b, expected 0", k, in_ready[k]);
            end
        end
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < NW; k++) begin
            checks++;
            if (in_ready[k] !== 1'b1) begin
                errors++; $display("FAIL rel_in_ready dut%0d: got %b, expected 1", k, in_ready[k]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_add8();
        send(0, 64'h0D, 64'h0B, 1'b0, 1'b0, mk(64'h18, 1'b0, 1'b0, 1'b0));
        // The acceptance edge is the first of three register edges.
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checks++;
            if (out_valid[0] !== (n == 2)) begin
                errors++; $display("FAIL latency dut0 cycle %0d: out_valid=%b, expected %b", n, out_valid[0], (n == 2));
            end
        end
        @(posedge clk); #1;
        send(0, 64'hFF, 64'hFF, 1'b1, 1'b0, mk(64'hFF, 1'b1, 1'b0, 1'b0));
        send(0, 64'h00, 64'h00, 1'b0, 1'b0, mk(64'h00, 1'b0, 1'b0, 1'b1));
        for (int t = 0; t < 50 && q[0].size() != 0; t++) @(posedge clk);
        checks++;
        if (q[0].size() != 0) begin
            errors++; $display("FAIL add8_drain: %0d results outstanding, expected 0", q[0].size());
        end
        #1;
    endtask

    task automatic test_ovf8();
        send(0, 64'h7F, 64'h01, 1'b0, 1'b0, mk(64'h80, 1'b0, 1'b1, 1'b0));
        send(0, 64'h00, 64'h01, 1'b0, 1'b1, mk(64'hFF, 1'b0, 1'b0, 1'b0));
        send(0, 64'h80, 64'h01, 1'b0, 1'b1, mk(64'h7F, 1'b1, 1'b1, 1'b0));
        send(0, 64'h05, 64'h02, 1'b1, 1'b1, mk(64'h02, 1'b1, 1'b0, 1'b0));
        send(0, 64'h00, 64'h00, 1'b0, 1'b1, mk(64'h00, 1'b1, 1'b0, 1'b1));
        for (int t = 0; t < 50 && q[0].size() != 0; t++) @(posedge clk);
        checks++;
        if (q[0].size() != 0) begin
            errors++; $display("FAIL ovf8_drain: %0d results outstanding, expected 0", q[0].size());
        end
        #1;
    endtask

    task automatic test_backpressure();
        int   base_sent, base_out;
        logic [66:0] held;
        exp_t first;
        base_sent = sent_cnt[1];
        base_out  = nout[1];
        first     = model(16, 64'h1234, 64'h0F0F, 1'b0, 1'b0);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    logic [63:0] a, b;
                    a = 64'h1234 * (i + 1);
                    b = 64'h0F0F ^ (64'h1111 * i);
                    send(1, a, b, i[0], i[1], model(16, a, b, i[0], i[1]));
                end
            end
            begin
                out_ready[1] = 1'b0;
                repeat (4) @(negedge clk);
                held = {sum_s[1], cout_s[1], ovf_s[1], zero_s[1]};
                checks++;
                if (in_ready[1] !== 1'b0 || out_valid[1] !== 1'b1) begin
                    errors++; $display("FAIL bp_full: in_ready=%b out_valid=%b, expected 0 and 1", in_ready[1], out_valid[1]);
                end
                checks++;
                if (held !== first) begin
                    errors++; $display("FAIL bp_head: got %h, expected %h", held, first);
                end
                @(negedge clk);
                checks++;
                if (sent_cnt[1] - base_sent != 3) begin
                    errors++; $display("FAIL bp_buffered: accepted %0d, expected 3", sent_cnt[1] - base_sent);
                end
                checks++;
                if (in_ready[1] !== 1'b0) begin
                    errors++; $display("FAIL bp_in_ready: got %b, expected 0", in_ready[1]);
                end
                checks++;
                if ({sum_s[1], cout_s[1], ovf_s[1], zero_s[1]} !== held) begin
                    errors++; $display("FAIL bp_stable: got %h, expected %h", {sum_s[1], cout_s[1], ovf_s[1], zero_s[1]}, held);
                end
                @(posedge clk);
                #1 out_ready[1] = 1'b1;
            end
        join
        for (int t = 0; t < 50 && q[1].size() != 0; t++) @(posedge clk);
        #1;
        checks++;
        if (nout[1] - base_out != 6) begin
            errors++; $display("FAIL bp_count: got %0d results, expected 6", nout[1] - base_out);
        end
    endtask

    task automatic test_reset_midstream();
        int base_out;
        out_ready[0] = 1'b0;
        send(0, 64'h3C, 64'h11, 1'b0, 1'b0, mk(64'h4D, 1'b0, 1'b0, 1'b0));
        send(0, 64'h20, 64'h05, 1'b0, 1'b0, mk(64'h25, 1'b0, 1'b0, 1'b0));
        send(0, 64'h40, 64'h02, 1'b0, 1'b1, mk(64'h3E, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        checks++;
        if (out_valid[0] !== 1'b1 || sum_s[0] !== 64'h4D) begin
            errors++; $display("FAIL mid_pre: out_valid=%b sum=%h, expected 1 and 4d", out_valid[0], sum_s[0]);
        end
        rst_n = 1'b0;
        #1;
        q[0].delete();
        checks++;
        if ({out_valid[0], sum_s[0], cout_s[0], ovf_s[0], zero_s[0], in_ready[0]} !== 69'd0) begin
            errors++; $display("FAIL mid_rst: out_valid=%b sum=%h c=%b o=%b z=%b in_ready=%b, expected all 0",
                               out_valid[0], sum_s[0], cout_s[0], ovf_s[0], zero_s[0], in_ready[0]);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready[0] = 1'b1;
        base_out = nout[0];
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checks++;
            if (out_valid[0] !== 1'b0) begin
                errors++; $display("FAIL mid_ghost cycle %0d: out_valid=%b, expected 0", n, out_valid[0]);
            end
        end
        @(posedge clk); #1;
        send(0, 64'h21, 64'h12, 1'b0, 1'b0, mk(64'h33, 1'b0, 1'b0, 1'b0));
        for (int t = 0; t < 50 && q[0].size() != 0; t++) @(posedge clk);
        #1;
        checks++;
        if (nout[0] - base_out != 1) begin
            errors++; $display("FAIL mid_after: got %0d results, expected 1", nout[0] - base_out);
        end
    endtask

    task automatic test_random();
        int base_out;
        base_out  = nout[2];
        rand_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 10000; n++) begin
                    logic [63:0] a, b;
                    logic        cin, sb;
                    a   = 64'($urandom);
                    b   = 64'($urandom);
                    cin = 1'($urandom_range(0, 1));
                    sb  = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 15) == 0) a = 64'hFFFF_FFFF;
                    if ($urandom_range(0, 15) == 0) b = 64'h8000_0000;
                    if ($urandom_range(0, 15) == 0) b = a;
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    send(2, a, b, cin, sb, model(32, a, b, cin, sb));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready[2] = ($urandom_range(0, 3) != 0);
                end
                out_ready[2] = 1'b1;
            end
        join
        for (int t = 0; t < 200 && q[2].size() != 0; t++) @(posedge clk);
        #1;
        checks++;
        if (nout[2] - base_out != 10000) begin
            errors++; $display("FAIL rand_count: got %0d results, expected 10000", nout[2] - base_out);
        end
    endtask

    initial begin
        test_reset();
        test_add8();
        test_ovf8();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
